rob: RTL and testbench

//  Reorder buffer for the Qu core, downstream of front_end rename/dispatch. Provides rob_tail_ptr and

---
 rtl/qu_common_pkg.sv | 32 +++
 rtl/rob.sv | 187 ++++++++++++++++++
 tb/tb_rob.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/qu_common_pkg.sv
// Shared Qu core definitions used by the reorder buffer and its neighbours:
// ROB sizing, pointer/count types, the ROB entry layout and the ROB FSM states.
package qu_common;

  // Number of ROB entries; must be a power of two and at least 4.
  localparam int ROB_DEPTH          = 16;
  localparam int ROB_ADDR_WIDTH     = $clog2(ROB_DEPTH);
  localparam int PHY_RF_ADDR_WIDTH  = 6;
  localparam int ARCH_RF_ADDR_WIDTH = 5;

  typedef logic [ROB_ADDR_WIDTH-1:0]     rob_addr_t;
  typedef logic [ROB_ADDR_WIDTH:0]       rob_count_t;
  typedef logic [PHY_RF_ADDR_WIDTH-1:0]  phy_addr_t;
  typedef logic [ARCH_RF_ADDR_WIDTH-1:0] arch_addr_t;

  // One in-flight uop as tracked between dispatch and retirement.
  typedef struct packed {
    logic       valid;
    logic       done;
    logic       exc;
    logic       has_rd;
    arch_addr_t arch_rd;
    phy_addr_t  phy_rd;
    phy_addr_t  old_phy_rd;
  } rob_entry_t;

  typedef enum logic {
    ROB_RUN   = 1'b0,
    ROB_FLUSH = 1'b1
  } rob_state_t;

endpackage

// File: rtl/rob.sv
// Reorder buffer for the Qu core. Entries are allocated at the tail by
// rename/dispatch, marked done (optionally with an exception) by the execution
// units, and retired in program order from the head, one per cycle. An
// exception at the head suppresses its commit and triggers a one-cycle flush
// that empties the buffer.
// Optional feature: define QU_ROB_PERF_CNT_EN to add the 32-bit commit_cnt
// output counting retired uops.
module rob
  import qu_common::*;
(
  input  logic       clk,
  input  logic       rst,
  // allocation from rename/dispatch
  input  logic       alloc_en,
  input  logic       alloc_has_rd,
  input  arch_addr_t alloc_arch_rd,
  input  phy_addr_t  alloc_phy_rd,
  input  phy_addr_t  alloc_old_phy_rd,
  output rob_addr_t  tail_ptr,
  output logic       full,
  output logic       empty,
  output rob_count_t count,
  // completion from execution units
  input  logic       cmpl_en,
  input  rob_addr_t  cmpl_addr,
  input  logic       cmpl_exc,
  // retirement
  output logic       commit_en,
  output logic       commit_has_rd,
  output arch_addr_t commit_arch_rd,
  output phy_addr_t  commit_phy_rd,
  output phy_addr_t  commit_old_phy_rd,
  output logic       flush
`ifdef QU_ROB_PERF_CNT_EN
  ,
  output logic [31:0] commit_cnt
`endif
);

  rob_entry_t entries [ROB_DEPTH];
  rob_state_t state;
  rob_state_t state_next;
  rob_addr_t  head;
  rob_addr_t  tail;
  rob_count_t count_q;
  rob_entry_t head_entry;

  logic in_run;
  logic do_alloc;
  logic do_cmpl;
  logic do_commit;
  logic do_exc;

  // Occupancy flags come straight from the registered count so they are
  // stable for the whole cycle and never depend on this cycle's requests.
  assign count    = count_q;
  assign full     = (count_q == rob_count_t'(ROB_DEPTH));
  assign empty    = (count_q == '0);
  assign tail_ptr = tail;

  assign in_run     = (state == ROB_RUN);
  assign head_entry = entries[head];

  assign do_alloc  = alloc_en && !full && in_run;
  // A completion aimed at the slot being allocated this cycle is illegal
  // upstream; the allocation owns the slot, so the completion is dropped.
  assign do_cmpl   = cmpl_en && in_run && entries[cmpl_addr].valid &&
                     !(do_alloc && (cmpl_addr == tail));
  assign do_commit = in_run && head_entry.valid && head_entry.done && !head_entry.exc;
  assign do_exc    = in_run && head_entry.valid && head_entry.done &&  head_entry.exc;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ROB_RUN;
    end else begin
      // NOTE: every clocked assignment uses <= so all flops sample pre-edge values together.
      state <= state_next;
    end
  end

  // FSM next state and the flush pulse, which is high exactly while in FLUSH.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_next = state;
    flush      = 1'b0;
    unique case (state)
      ROB_RUN: begin
        if (do_exc) state_next = ROB_FLUSH;
      end
      ROB_FLUSH: begin
        flush      = 1'b1;
        state_next = ROB_RUN;
      end
      default: state_next = ROB_RUN;
    endcase
  end

  // Entry array: alloc and completion write ports, commit clears valid,
  // flush clears every entry's status bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the array is reset because valid/done/exc must read 0 straight out of reset;
      // a payload-only RAM without reset would be fine, but these status bits are control.
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (state == ROB_FLUSH) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries[i].valid <= 1'b0;
        entries[i].done  <= 1'b0;
        entries[i].exc   <= 1'b0;
      end
    end else begin
      if (do_cmpl) begin
        entries[cmpl_addr].done <= 1'b1;
        entries[cmpl_addr].exc  <= cmpl_exc;
      end
      if (do_alloc) begin
        entries[tail] <= '{valid:      1'b1,
                           done:       1'b0,
                           exc:        1'b0,
                           has_rd:     alloc_has_rd,
                           arch_rd:    alloc_arch_rd,
                           phy_rd:     alloc_phy_rd,
                           old_phy_rd: alloc_old_phy_rd};
      end
      // Head and tail only coincide when full (alloc refused) or empty
      // (no commit), so this never collides with the alloc write.
      if (do_commit) begin
        entries[head].valid <= 1'b0;
      end
    end
  end

  // Head/tail pointers and occupancy count; pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else if (state == ROB_FLUSH) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (do_alloc)  tail <= tail + rob_addr_t'(1);
      if (do_commit) head <= head + rob_addr_t'(1);
      if (do_alloc && !do_commit) begin
        count_q <= count_q + rob_count_t'(1);
      end else if (do_commit && !do_alloc) begin
        count_q <= count_q - rob_count_t'(1);
      end
    end
  end

  // Registered retire interface: one-cycle commit_en with the head fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      commit_en         <= 1'b0;
      commit_has_rd     <= 1'b0;
      commit_arch_rd    <= '0;
      commit_phy_rd     <= '0;
      commit_old_phy_rd <= '0;
    end else begin
      commit_en <= do_commit;
      if (do_commit) begin
        commit_has_rd     <= head_entry.has_rd;
        commit_arch_rd    <= head_entry.arch_rd;
        commit_phy_rd     <= head_entry.phy_rd;
        commit_old_phy_rd <= head_entry.old_phy_rd;
      end
    end
  end

`ifdef QU_ROB_PERF_CNT_EN
  // Retired-uop counter; survives flushes and wraps at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      commit_cnt <= '0;
    end else if (commit_en) begin
      commit_cnt <= commit_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rob.sv
// Directed self-checking bench for the Qu reorder buffer: reset, fill/overflow,
// out-of-order completion, pointer wrap, exception flush, full+commit.
module tb_rob;
  import qu_common::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       alloc_en = 1'b0;
  logic       alloc_has_rd = 1'b0;
  arch_addr_t alloc_arch_rd = '0;
  phy_addr_t  alloc_phy_rd = '0;
  phy_addr_t  alloc_old_phy_rd = '0;
  rob_addr_t  tail_ptr;
  logic       full;
  logic       empty;
  rob_count_t count;
  logic       cmpl_en = 1'b0;
  rob_addr_t  cmpl_addr = '0;
  logic       cmpl_exc = 1'b0;
  logic       commit_en;
  logic       commit_has_rd;
  arch_addr_t commit_arch_rd;
  phy_addr_t  commit_phy_rd;
  phy_addr_t  commit_old_phy_rd;
  logic       flush;
`ifdef QU_ROB_PERF_CNT_EN
  logic [31:0] commit_cnt;
`endif

  int checks = 0;
  int errors = 0;

  rob dut (
    .clk               (clk),
    .rst               (rst),
    .alloc_en          (alloc_en),
    .alloc_has_rd      (alloc_has_rd),
    .alloc_arch_rd     (alloc_arch_rd),
    .alloc_phy_rd      (alloc_phy_rd),
    .alloc_old_phy_rd  (alloc_old_phy_rd),
    .tail_ptr          (tail_ptr),
    .full              (full),
    .empty             (empty),
    .count             (count),
    .cmpl_en           (cmpl_en),
    .cmpl_addr         (cmpl_addr),
    .cmpl_exc          (cmpl_exc),
    .commit_en         (commit_en),
    .commit_has_rd     (commit_has_rd),
    .commit_arch_rd    (commit_arch_rd),
    .commit_phy_rd     (commit_phy_rd),
    .commit_old_phy_rd (commit_old_phy_rd),
    .flush             (flush)
`ifdef QU_ROB_PERF_CNT_EN
    ,
    .commit_cnt        (commit_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one active edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Field values of an allocation are all derived from its phy_rd tag.
  task automatic set_alloc(input int phy);
    alloc_en         = 1'b1;
    alloc_has_rd     = 1'b1;
    alloc_arch_rd    = arch_addr_t'(phy);
    alloc_phy_rd     = phy_addr_t'(phy);
    alloc_old_phy_rd = phy_addr_t'(phy ^ 63);
  endtask

  task automatic alloc(input int phy);
    set_alloc(phy);
    tick();
    alloc_en = 1'b0;
  endtask

  task automatic cmpl(input int idx, input logic exc);
    cmpl_en   = 1'b1;
    cmpl_addr = rob_addr_t'(idx);
    cmpl_exc  = exc;
    tick();
    cmpl_en  = 1'b0;
    cmpl_exc = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got=0 expected=1");
    $fatal(1, "timeout");
  end

  initial begin
    int ak;
    int ck;
    int rk;
    int maxc;

    // ---- reset state
    #3;
    check("rst_count",  32'(count), 0);
    check("rst_empty",  32'(empty), 1);
    check("rst_full",   32'(full), 0);
    check("rst_tail",   32'(tail_ptr), 0);
    check("rst_commit", 32'(commit_en), 0);
    check("rst_flush",  32'(flush), 0);
    tick();
    rst = 1'b1;

    // ---- 1: async reset mid-run with 5 valid entries and a commit in flight
    for (int i = 1; i <= 6; i++) alloc(i);
    check("t1_count6", 32'(count), 6);
    cmpl(0, 1'b0);
    tick();
    check("t1_commit_en", 32'(commit_en), 1);
    check("t1_commit_phy", 32'(commit_phy_rd), 1);
    check("t1_count5", 32'(count), 5);
    #2;
    rst = 1'b0;
    #1;
    check("t1_async_count",  32'(count), 0);
    check("t1_async_empty",  32'(empty), 1);
    check("t1_async_tail",   32'(tail_ptr), 0);
    check("t1_async_commit", 32'(commit_en), 0);
    tick();
    check("t1_no_flush", 32'(flush), 0);
    rst = 1'b1;

    // ---- 2: fill, overflow; 6: full + commit in the same cycle
    for (int i = 0; i < 16; i++) alloc(16 + i);
    check("t2_full",  32'(full), 1);
    check("t2_count", 32'(count), 16);
    check("t2_tail",  32'(tail_ptr), 0);
    check("t2_empty", 32'(empty), 0);
    alloc(40);
    check("t2_drop_count", 32'(count), 16);
    check("t2_drop_tail",  32'(tail_ptr), 0);
    cmpl(0, 1'b0);
    check("t6_no_commit_yet", 32'(commit_en), 0);
    alloc(41);
    check("t6_commit_en",  32'(commit_en), 1);
    check("t6_commit_phy", 32'(commit_phy_rd), 16);
    check("t6_count",      32'(count), 15);
    check("t6_tail",       32'(tail_ptr), 0);
    check("t6_full",       32'(full), 0);
    tick();
    check("t6_single_pulse", 32'(commit_en), 0);
`ifdef QU_ROB_PERF_CNT_EN
    check("t6_commit_cnt", commit_cnt, 1);
`endif

    // ---- 3: out-of-order completion, in-order retirement
    do_reset();
    for (int i = 0; i < 4; i++) alloc(40 + i);
    cmpl(3, 1'b0);
    check("t3_c3_hold", 32'(commit_en), 0);
    cmpl(1, 1'b0);
    check("t3_c1_hold", 32'(commit_en), 0);
    cmpl(2, 1'b0);
    check("t3_c2_hold", 32'(commit_en), 0);
    cmpl(0, 1'b0);
    check("t3_c0_latency", 32'(commit_en), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_commit_en",  32'(commit_en), 1);
      check("t3_commit_phy", 32'(commit_phy_rd), 40 + i);
    end
    check("t3_has_rd",  32'(commit_has_rd), 1);
    check("t3_arch_rd", 32'(commit_arch_rd), (43 & 31));
    check("t3_old_phy", 32'(commit_old_phy_rd), (43 ^ 63));
    tick();
    check("t3_done_en",    32'(commit_en), 0);
    check("t3_done_empty", 32'(empty), 1);

    // ---- 4: 20 allocations across the 15->0 wrap with interleaved commits
    do_reset();
    ak = 0; ck = 0; rk = 0; maxc = 0;
    for (int c = 0; c < 80 && rk < 20; c++) begin
      if (ak < 20) set_alloc(10 + ak);
      cmpl_en   = (c >= 8) && (ck < ak);
      cmpl_addr = rob_addr_t'(ck);
      tick();
      if (alloc_en) ak++;
      if (cmpl_en) ck++;
      alloc_en = 1'b0;
      cmpl_en  = 1'b0;
      if (commit_en) begin
        check("t4_order_phy", 32'(commit_phy_rd), 10 + rk);
        rk++;
      end
      if (int'(count) > maxc) maxc = int'(count);
    end
    check("t4_commits", rk, 20);
    check("t4_count_bound", 32'(maxc <= 16), 1);
    check("t4_tail_wrapped", 32'(tail_ptr), 4);
    tick();
    check("t4_empty", 32'(empty), 1);

    // ---- 5: exception at head -> flush
    do_reset();
    for (int i = 0; i < 3; i++) alloc(50 + i);
    cmpl(0, 1'b0);
    cmpl(1, 1'b1);
    check("t5_commit0_en",  32'(commit_en), 1);
    check("t5_commit0_phy", 32'(commit_phy_rd), 50);
    check("t5_no_flush_yet", 32'(flush), 0);
    cmpl(2, 1'b0);
    check("t5_flush",        32'(flush), 1);
    check("t5_exc_no_commit", 32'(commit_en), 0);
    check("t5_flush_count",  32'(count), 2);
    // alloc and completion during FLUSH are ignored
    set_alloc(55);
    cmpl_en   = 1'b1;
    cmpl_addr = rob_addr_t'(2);
    tick();
    alloc_en = 1'b0;
    cmpl_en  = 1'b0;
    check("t5_flush_once",  32'(flush), 0);
    check("t5_post_commit", 32'(commit_en), 0);
    check("t5_post_count",  32'(count), 0);
    check("t5_post_tail",   32'(tail_ptr), 0);
    check("t5_post_empty",  32'(empty), 1);
    tick();
    check("t5_still_quiet", 32'(commit_en), 0);
    alloc(60);
    check("t5_new_tail",  32'(tail_ptr), 1);
    check("t5_new_count", 32'(count), 1);
    cmpl(0, 1'b0);
    tick();
    check("t5_new_commit_en",  32'(commit_en), 1);
    check("t5_new_commit_phy", 32'(commit_phy_rd), 60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
